registers_bank_dump_ctrl: RTL
=============================

# registers_bank_dump_ctrl

Debug-side controller that takes ownership of the register bank's port A and streams all registers out as bytes to the debug UART transmitter. While idle it is transparent: the pipeline's read address and jr/jalr select pass straight through. On a start request it reads r0 through r(BANK_DEPTH-1) in order and serializes each word MSB-byte first over a start/done byte handshake. It then signals completion and returns port A to the pipeline.

## Interface
Parameters:
- NB_DATA, 32, register width
- NB_ADDR, 5, register address width
- BANK_DEPTH, 32, number of registers dumped
- NB_BYTE, 8, transmit byte width; NB_DATA must be a multiple of NB_BYTE

Ports:
- i_clock  in  1  clock; all state changes on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_pipe_read_reg_a  in  NB_ADDR  pipeline port-A address
- i_pipe_jr_jalr  in  1  pipeline jr/jalr select
- i_data_a  in  NB_DATA  bank port-A read data, registered with 1-cycle latency
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte
- o_read_reg_a  out  NB_ADDR  address driven to bank port A
- o_jr_jalr  out  1  jr/jalr select driven to bank
- o_tx_start  out  1  one-cycle pulse: o_tx_data is valid, send it
- o_tx_data  out  NB_BYTE  byte to transmit
- o_busy  out  1  high whenever state is not IDLE; pipeline must be halted while high
- o_done  out  1  one-cycle pulse when the last byte is acknowledged

## Operation
- States: IDLE, ADDR, LATCH, SEND, WAIT_TX, DONE.
- IDLE:
  - o_read_reg_a = i_pipe_read_reg_a and o_jr_jalr = i_pipe_jr_jalr (combinational pass-through).
  - i_start=1 moves to ADDR, with reg index = 0 and byte count = 0.
- ADDR:
  - o_read_reg_a = reg index, o_jr_jalr = 0.
  - The bank samples the address on this edge. Go to LATCH.
- LATCH:
  - Address held. i_data_a is valid this cycle.
  - Capture it into the shift register. Go to SEND.
- SEND:
  - o_tx_start = 1 and o_tx_data = shift register [NB_DATA-1 -: NB_BYTE].
  - Go to WAIT_TX.
- WAIT_TX: wait for i_tx_done.
  - If the byte was not the last of the word: shift left by NB_BYTE, increment byte count, go to SEND.
  - If it was the last byte and reg index < BANK_DEPTH-1: increment reg index, clear byte count, go to ADDR.
  - If it was the last byte of the last register: go to DONE.
- DONE: o_done = 1 for one cycle, then go to IDLE.
- The reg index counter is NB_ADDR+1 bits wide, so BANK_DEPTH = 2^NB_ADDR does not wrap. Only its low NB_ADDR bits drive o_read_reg_a.
- i_start outside IDLE is ignored; no queuing.
- i_tx_done outside WAIT_TX is ignored.
- o_jr_jalr is held at 0 in every non-IDLE state, so r31 is never forced during a dump.
- The address is held stable from ADDR through WAIT_TX.

## Timing
- Reset values:
  - State IDLE, reg index 0, byte count 0, shift register 0.
  - o_tx_start = 0, o_tx_data = 0, o_busy = 0, o_done = 0.
  - o_read_reg_a and o_jr_jalr follow the pass-through inputs.
- Reset asserted mid-dump: return to IDLE on the next edge. No o_done pulse, and any in-flight byte is abandoned.
- Start to first o_tx_start: i_start sampled at edge 0. ADDR covers cycle 1, LATCH cycle 2, and o_tx_start is high in cycle 3.
- i_tx_done to next o_tx_start:
  - Same word: 1 cycle (the next cycle).
  - Next register: 3 cycles (ADDR, LATCH, SEND).
- Minimum total cycles with zero-wait tx is BANK_DEPTH·(2 + 2·NB_DATA/NB_BYTE) + 2. This is 322 for the default parameters.
- o_tx_start and o_done are registered (state-decoded), one cycle wide, and never high in the same cycle.

## Structure
- Shared package holds the state encoding constants (3-bit: IDLE=0, ADDR=1, LATCH=2, SEND=3, WAIT_TX=4, DONE=5) and BYTES_PER_WORD = NB_DATA/NB_BYTE.
- Single module with no sub-modules. The port-A mux is inline combinational logic.

## Test plan
- Reset with i_pipe_read_reg_a=7 and i_pipe_jr_jalr=1:
  - Outputs show o_read_reg_a=7, o_jr_jalr=1, o_busy=0.
  - Changing the input to 12 changes o_read_reg_a to 12 in the same cycle.
- Bank preloaded with r0=0, r1=0x11223344, r31=0xDEADBEEF; tx echoes done 1 cycle after each start. Required response:
  - 128 o_tx_start pulses.
  - Bytes 4–7 are 11,22,33,44.
  - Bytes 124–127 are DE,AD,BE,EF.
  - o_done pulses once, 322 cycles after start.
- i_tx_done delayed 10 cycles per byte: o_read_reg_a stays constant between ADDR and the last byte of each word, and no extra o_tx_start pulses appear.
- i_start re-pulsed during a dump, plus spurious i_tx_done in ADDR or LATCH: byte sequence and count are unchanged.
- Reset asserted in WAIT_TX of r5 byte 2: next cycle o_busy=0, with no o_done pulse. A new i_start then dumps from r0.
- i_pipe_jr_jalr=1 throughout the dump: o_jr_jalr=0 while busy, and byte data matches registers[index], not r31.

Source files
------------

// File: rtl/registers_bank_dump_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// registers_bank_dump_ctrl_pkg
// Shared definitions for the register-bank dump controller: FSM state encoding
// and the bytes-per-word helper used to size the byte counter.
// -----------------------------------------------------------------------------
package registers_bank_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_DONE    = 3'd5
    } dump_state_e;

    localparam int DEF_NB_DATA = 32;
    localparam int DEF_NB_BYTE = 8;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEF_NB_DATA, DEF_NB_BYTE);

endpackage

// File: rtl/registers_bank_dump_ctrl.sv
// -----------------------------------------------------------------------------
// registers_bank_dump_ctrl
// Takes over register-bank port A on request and streams r0..r(BANK_DEPTH-1)
// to the debug UART transmitter, MSB byte first, one byte per start/done
// handshake. While idle, port A is a transparent pass-through of the pipeline.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_start                 dump request (only honoured in IDLE)
//   i_pipe_read_reg_a       pipeline port-A address
//   i_pipe_jr_jalr          pipeline jr/jalr select
//   i_data_a                bank port-A read data (1-cycle registered read)
//   i_tx_done               transmitter finished the current byte (pulse)
//   o_read_reg_a            address to bank port A
//   o_jr_jalr               jr/jalr select to bank (forced 0 while dumping)
//   o_tx_start, o_tx_data   byte-send pulse and byte
//   o_busy                  dump in progress; pipeline must stay halted
//   o_done                  pulse after the last byte is acknowledged
// -----------------------------------------------------------------------------
module registers_bank_dump_ctrl
    import registers_bank_dump_ctrl_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int BANK_DEPTH = 32,
    parameter int NB_BYTE    = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_pipe_read_reg_a,
    input  logic               i_pipe_jr_jalr,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic               i_tx_done,
    output logic [NB_ADDR-1:0] o_read_reg_a,
    output logic               o_jr_jalr,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    // One extra bit so that BANK_DEPTH = 2^NB_ADDR never wraps the index.
    localparam int IDX_W = NB_ADDR + 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [IDX_W-1:0] LAST_REG  = IDX_W'(BANK_DEPTH - 1);

    dump_state_e        state_q, state_d;
    logic [IDX_W-1:0]   reg_idx_q, reg_idx_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               tx_start_q, tx_start_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_ADDR;
                    reg_idx_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                // Bank samples the address on the edge that leaves this state.
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                shift_d = i_data_a;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        shift_d    = shift_q << NB_BYTE;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        state_d    = ST_SEND;
                    end else if (reg_idx_q < LAST_REG) begin
                        reg_idx_d  = reg_idx_q + IDX_W'(1);
                        byte_cnt_d = '0;
                        state_d    = ST_ADDR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come out of flops
        // aligned with the state they belong to.
        tx_start_d = (state_d == ST_SEND);
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            reg_idx_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Port-A ownership mux: pipeline when idle, dump index otherwise. jr/jalr
    // is forced low during a dump so r31 is never substituted for the index.
    always_comb begin
        if (state_q == ST_IDLE) begin
            o_read_reg_a = i_pipe_read_reg_a;
            o_jr_jalr    = i_pipe_jr_jalr;
        end else begin
            o_read_reg_a = reg_idx_q[NB_ADDR-1:0];
            o_jr_jalr    = 1'b0;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = shift_q[NB_DATA-1 -: NB_BYTE];
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule
